// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings for the program counter unit
//
// Purpose: target-select and branch-condition encodings plus the default
// PC width, shared by pc_unit_ras and its bench.
// Ports: none (package).

package pc_pkg;

  localparam int PC_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    PC_SRC_SEQ = 2'b00,
    PC_SRC_IMM = 2'b01,
    PC_SRC_JR  = 2'b10,
    PC_SRC_RET = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    BR_BEQ    = 2'b00,
    BR_BNE    = 2'b01,
    BR_BLT    = 2'b10,
    BR_ALWAYS = 2'b11
  } br_cond_e;

  // Selected ALU-flag condition for a conditional branch.
  function automatic logic branch_taken(input logic [1:0] sel,
                                        input logic zero,
                                        input logic neg);
    logic r;
    r = 1'b1;
    case (br_cond_e'(sel))
      BR_BEQ:    r = zero;
      BR_BNE:    r = ~zero;
      BR_BLT:    r = neg;
      BR_ALWAYS: r = 1'b1;
      default:   r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack
//
// Purpose: RAS_DEPTH-entry return stack. Overflow overwrites the oldest
// entry; popping an empty stack leaves it unchanged.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push, pop        operations; both together replace the top entry
//                    (or push onto an empty stack)
//   din              value to push / replace with
//   top              current top entry (undefined when count == 0)
//   count            number of valid entries
//   overflow         strobe: push onto a full stack this cycle
//   underflow        strobe: pop of an empty stack this cycle

module ras_stack #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    sp;
  logic [PW-1:0]    sp_m1;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic [PW-1:0]    wr_addr;

  assign sp_m1 = sp - PW'(1);
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign top   = mem[sp_m1];

  assign overflow  = push & ~pop & full;
  assign underflow = pop & empty;

  // Replace-top writes below the pointer; every other write goes at it.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sp;
    if (!reset && push) begin
      wr_en   = 1'b1;
      wr_addr = (pop && !empty) ? sp_m1 : sp;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp    <= '0;
      count <= '0;
    end else if (push && pop) begin
      if (empty) begin
        sp    <= sp + PW'(1);
        count <= CW'(1);
      end
    end else if (push) begin
      // Pointer wraps freely; once full the oldest slot is overwritten.
      sp <= sp + PW'(1);
      if (!full) begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      sp    <= sp_m1;
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - parametrised program counter with return-address stack
//
// Purpose: PC register, target mux, branch qualifier and sticky RAS error.
// Optional macro PC_ALIGN_CHECK_EN: odd targets are refused and flagged on
// align_fault for the following cycle.
// Ports:
//   CLK, reset                 clock, synchronous active-high reset
//   stall                      freeze PC and RAS
//   pc_write, branch           unconditional / conditional update enables
//   br_cond, zero, neg         branch condition select and ALU flags
//   pc_src                     target select (seq / imm / jr / return)
//   seq_in, imm, jr_in         target sources
//   call                       push seq_in when the update fires
//   pc_out                     current PC (registered)
//   ras_count, ras_empty,
//   ras_full, ras_err          stack status; ras_err is sticky
//   align_fault                (PC_ALIGN_CHECK_EN only) odd-target refusal

module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH_DEF,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       pc_write,
  input  logic                       branch,
  input  logic [1:0]                 br_cond,
  input  logic                       zero,
  input  logic                       neg,
  input  logic [1:0]                 pc_src,
  input  logic [WIDTH-1:0]           seq_in,
  input  logic [WIDTH-1:0]           imm,
  input  logic [WIDTH-1:0]           jr_in,
  input  logic                       call,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_err
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                       align_fault
`endif
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             cond;
  logic             upd;
  logic             fire;
  logic [WIDTH-1:0] imm_tgt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic             is_ret;
  logic             push;
  logic             pop;
  logic             ovf;
  logic             udf;

  assign cond    = branch_taken(br_cond, zero, neg);
  assign upd     = ~stall & (pc_write | (branch & cond));
  assign imm_tgt = imm << 1;
  assign is_ret  = (pc_src_e'(pc_src) == PC_SRC_RET);

  always_comb begin
    target = seq_in;
    case (pc_src_e'(pc_src))
      PC_SRC_SEQ: target = seq_in;
      PC_SRC_IMM: target = imm_tgt;
      PC_SRC_JR:  target = jr_in;
      PC_SRC_RET: target = ras_empty ? RESET_VEC : ras_top;
      default:    target = seq_in;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic odd_fault;

  assign odd_fault = upd & target[0];
  assign fire      = upd & ~target[0];

  always_ff @(posedge CLK) begin
    if (reset) begin
      align_fault <= 1'b0;
    end else begin
      align_fault <= odd_fault;
    end
  end
`else
  assign fire = upd;
`endif

  // call + return together reaches the stack as push+pop (replace top).
  assign push = fire & call;
  assign pop  = fire & is_ret;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (seq_in),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ovf),
    .underflow (udf)
  );

  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_out  <= RESET_VEC;
      ras_err <= 1'b0;
    end else begin
      if (fire) begin
        pc_out <= target;
      end
      if (ovf || udf) begin
        ras_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - self-checking bench for pc_unit_ras

module tb_pc_unit_ras;

  localparam int          W     = 16;
  localparam int          D     = 4;
  localparam logic [15:0] RV    = 16'h0100;
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [15:0] ODD_EXP = RV;
`else
  localparam logic [15:0] ODD_EXP = 16'h0203;
`endif

  logic          CLK = 1'b0;
  logic          reset, stall, pc_write, branch, zero, neg, call;
  logic [1:0]    br_cond, pc_src;
  logic [W-1:0]  seq_in, imm, jr_in, pc_out;
  logic [2:0]    ras_count;
  logic          ras_empty, ras_full, ras_err;
`ifdef PC_ALIGN_CHECK_EN
  logic          align_fault;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pc_unit_ras #(
    .WIDTH(W), .RAS_DEPTH(D), .RESET_VEC(RV)
  ) dut (
    .CLK(CLK), .reset(reset), .stall(stall), .pc_write(pc_write),
    .branch(branch), .br_cond(br_cond), .zero(zero), .neg(neg),
    .pc_src(pc_src), .seq_in(seq_in), .imm(imm), .jr_in(jr_in),
    .call(call), .pc_out(pc_out), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
`ifdef PC_ALIGN_CHECK_EN
    , .align_fault(align_fault)
`endif
  );

  typedef struct {
    logic        rst, stl, pw, br;
    logic [1:0]  bc;
    logic        z, n;
    logic [1:0]  src;
    logic [15:0] seq, im, jr;
    logic        cl;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vt[$];

  // Behavioural model: the stack is a queue, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] mq[$];
  logic        m_err;
  logic        m_af;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, stl, pw, br, input logic [1:0] bc,
                     input logic z, n, input logic [1:0] src,
                     input logic [15:0] seq, im, jr, input logic cl,
                     input logic [15:0] e_pc, input logic [2:0] e_cnt, input logic e_err);
    vec_t v;
    v.rst = rst; v.stl = stl; v.pw = pw; v.br = br; v.bc = bc; v.z = z; v.n = n;
    v.src = src; v.seq = seq; v.im = im; v.jr = jr; v.cl = cl;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_err = e_err;
    vt.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; pc_write = v.pw; branch = v.br;
    br_cond = v.bc; zero = v.z; neg = v.n; pc_src = v.src;
    seq_in = v.seq; imm = v.im; jr_in = v.jr; call = v.cl;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_step(input vec_t v);
    logic        c, u;
    logic [15:0] t;
    if (v.rst) begin
      m_pc = RV; mq.delete(); m_err = 1'b0; m_af = 1'b0;
      return;
    end
    case (v.bc)
      2'd0: c = v.z;
      2'd1: c = !v.z;
      2'd2: c = v.n;
      default: c = 1'b1;
    endcase
    u = !v.stl && (v.pw || (v.br && c));
    case (v.src)
      2'd0: t = v.seq;
      2'd1: t = (v.im * 16'd2);
      2'd2: t = v.jr;
      default: t = (mq.size() > 0) ? mq[mq.size()-1] : RV;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    m_af = u && t[0];
    if (m_af) u = 1'b0;
`endif
    if (!u) return;
    m_pc = t;
    if (v.cl && v.src == 2'd3) begin
      if (mq.size() == 0) begin m_err = 1'b1; mq.push_back(v.seq); end
      else mq[mq.size()-1] = v.seq;
    end else if (v.cl) begin
      if (mq.size() == D) begin void'(mq.pop_front()); m_err = 1'b1; end
      mq.push_back(v.seq);
    end else if (v.src == 2'd3) begin
      if (mq.size() == 0) m_err = 1'b1;
      else void'(mq.pop_back());
    end
  endtask

  task automatic chk_model(input int i);
    chk($sformatf("rnd%0d.pc", i), pc_out, m_pc);
    chk($sformatf("rnd%0d.cnt", i), ras_count, mq.size());
    chk($sformatf("rnd%0d.err", i), ras_err, m_err);
    chk($sformatf("rnd%0d.empty", i), ras_empty, mq.size() == 0);
    chk($sformatf("rnd%0d.full", i), ras_full, mq.size() == D);
`ifdef PC_ALIGN_CHECK_EN
    chk($sformatf("rnd%0d.af", i), align_fault, m_af);
`endif
  endtask

  vec_t hv;

  initial begin
    reset = 1'b1; stall = 0; pc_write = 0; branch = 0; br_cond = 0; zero = 0;
    neg = 0; pc_src = 0; seq_in = 0; imm = 0; jr_in = 0; call = 0;

    //   rst stl pw br bc z n src seq      imm      jr       cl  pc       cnt err
    add(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0102, 16'h0000, 16'h0000, 0, 16'h0102, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0, 1, 16'h0000, 16'h0040, 16'h0000, 0, 16'h0102, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0, 1, 16'h0000, 16'h0040, 16'h0000, 0, 16'h0080, 0, 0);
    add(0, 0, 0, 1, 2, 0, 1, 1, 16'h0000, 16'h0041, 16'h0000, 0, 16'h0082, 0, 0);
    add(0, 0, 0, 1, 2, 0, 0, 1, 16'h0000, 16'h0050, 16'h0000, 0, 16'h0082, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 1, 16'h0000, 16'h0010, 16'h0000, 0, 16'h0020, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0011, 16'h0000, 0, 16'h0020, 0, 0);
    add(0, 0, 0, 1, 3, 0, 0, 1, 16'h0000, 16'hC001, 16'h0000, 0, 16'h8002, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 16'h0077, 16'h0000, 16'h0000, 1, 16'h8002, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0010, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0020, 16'h0000, 16'h0000, 1, 16'h0020, 2, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 1, 16'h0030, 3, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 16'h0000, 1, 16'h0040, 4, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0050, 16'h0000, 16'h0000, 1, 16'h0050, 4, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0050, 3, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0040, 2, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0030, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0020, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0100, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 16'h0000, 1, 16'h0100, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 1, 16'h0030, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0090, 16'h0000, 16'h0000, 1, 16'h0030, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0090, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'h0055, 16'h0000, 16'h0000, 1, 16'h0090, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 2, 16'h0000, 16'h0000, 16'h0204, 0, 16'h0204, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0066, 16'h0000, 16'h0000, 1, 16'h0100, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0066, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 2, 16'h0000, 16'h0000, 16'h0203, 0, ODD_EXP,  0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      chk($sformatf("vec%0d.pc", i), pc_out, vt[i].e_pc);
      chk($sformatf("vec%0d.cnt", i), ras_count, vt[i].e_cnt);
      chk($sformatf("vec%0d.err", i), ras_err, vt[i].e_err);
      chk($sformatf("vec%0d.empty", i), ras_empty, vt[i].e_cnt == 0);
      chk($sformatf("vec%0d.full", i), ras_full, vt[i].e_cnt == 3'd4);
    end

    hv = vt[0]; hv.rst = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("align.pulse", align_fault, 1'b1);
    drive(hv);
    chk("align.clear", align_fault, 1'b0);
    chk("align.pc", pc_out, RV);
`endif

    // Multi-cycle stall: two pushes, three stalled returns, then release.
    hv.pw = 1'b1; hv.cl = 1'b1; hv.src = 2'd0;
    hv.seq = 16'h0A00; drive(hv);
    hv.seq = 16'h0B00; drive(hv);
    hv.cl = 1'b0; hv.src = 2'd3; hv.stl = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(hv);
      chk($sformatf("stall%0d.pc", k), pc_out, 16'h0B00);
      chk($sformatf("stall%0d.cnt", k), ras_count, 3'd2);
    end
    hv.stl = 1'b0;
    drive(hv);
    chk("unstall.pc1", pc_out, 16'h0B00);
    chk("unstall.cnt1", ras_count, 3'd1);
    drive(hv);
    chk("unstall.pc2", pc_out, 16'h0A00);
    chk("unstall.cnt2", ras_count, 3'd0);
    chk("unstall.err", ras_err, 1'b0);

    // Randomised run against the queue model.
    hv = vt[0];
    drive(hv);
    model_step(hv);
    chk_model(-1);
    for (int i = 0; i < 400; i++) begin
      hv.rst  = ($urandom_range(0, 49) == 0);
      hv.stl  = ($urandom_range(0, 9) == 0);
      hv.pw   = $urandom_range(0, 1);
      hv.br   = $urandom_range(0, 1);
      hv.bc   = 2'($urandom_range(0, 3));
      hv.z    = $urandom_range(0, 1);
      hv.n    = $urandom_range(0, 1);
      hv.src  = 2'($urandom_range(0, 3));
      hv.seq  = 16'($urandom);
      hv.im   = 16'($urandom);
      hv.jr   = 16'($urandom);
      if ($urandom_range(0, 7) != 0) hv.seq[0] = 1'b0;
      if ($urandom_range(0, 7) != 0) hv.jr[0] = 1'b0;
      hv.cl   = ($urandom_range(0, 2) == 0);
      drive(hv);
      model_step(hv);
      chk_model(i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised next-generation program counter for the accumulator CPU.
- Generalises the 16-bit PC register, its source mux and its beq/bne qualifier to any width, with four branch conditions.
- Adds a hardware return-address stack (RAS) so call/return need no memory traffic.
- Sits between control unit/datapath and instruction memory; driven by control-unit PCWrite/Branch/PCSrc-style strobes.

Parameters:
- WIDTH, 16, PC and target width in bits (>= 8).
- RAS_DEPTH, 4, return-stack entries (power of 2, >= 2).
- RESET_VEC, 0, PC value after reset, WIDTH bits.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- stall  input  1  freezes PC and RAS this cycle, overriding every other input.
- pc_write  input  1  unconditional PC update enable.
- branch  input  1  conditional PC update enable.
- br_cond  input  2  condition select: 00 beq (zero), 01 bne (~zero), 10 blt (neg), 11 always.
- zero  input  1  ALU zero flag.
- neg  input  1  ALU sign flag.
- pc_src  input  2  target select: 00 seq_in, 01 imm target, 10 jr_in, 11 return (RAS top).
- seq_in  input  WIDTH  sequential target from datapath (PC+2).
- imm  input  WIDTH  zero-extended immediate; target = imm << 1, MSB dropped.
- jr_in  input  WIDTH  register-indirect target.
- call  input  1  push seq_in onto RAS when the update fires.
- pc_out  output  WIDTH  current PC.
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_count == 0.
- ras_full  output  1  ras_count == RAS_DEPTH.
- ras_err  output  1  sticky flag; set on RAS overflow or underflow.

Behaviour:
- Reset, synchronous with priority over everything:
  - pc_out = RESET_VEC.
  - ras_count = 0, ras_err = 0, stack pointer = 0.
  - Stack contents are don't-care.
- Condition: cond = selected flag per br_cond.
- Update enable: upd = ~stall & (pc_write | (branch & cond)).
  - When upd = 0, the PC and RAS hold; no side effects occur.
- PC update:
  - When upd = 1, pc_out <= target selected by pc_src on the next edge.
  - Latency is 1 cycle; pc_out is a registered output with no combinational path from inputs.
  - pc_src 01: target = {imm[WIDTH-2:0], 1'b0}.
- Push (upd & call & pc_src != 11):
  - Writes seq_in at the stack pointer.
  - Pointer increments modulo RAS_DEPTH.
  - ras_count increments, saturating at RAS_DEPTH.
  - If the stack was already full, the oldest entry is overwritten (circular) and ras_err is set.
- Pop (upd & pc_src == 11 & ~call):
  - Target = entry at pointer-1; pointer decrements and ras_count decrements.
  - If the stack is empty: target = RESET_VEC, pointer and count are unchanged, ras_err is set.
- Call plus return together (upd & call & pc_src == 11), i.e. a tail-call return:
  - Target = old top.
  - Top entry is replaced by seq_in; pointer and count are unchanged.
  - If the stack is empty, behaves as underflow and also pushes seq_in (count becomes 1).
- call with upd = 0: ignored.
- ras_err clears only on reset.
- Reset asserted in the same cycle as an update: reset wins and the update is discarded.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port align_fault (1 bit, registered).
  - When upd = 1 and the selected target has bit 0 set, the PC and RAS hold.
  - align_fault pulses high for exactly the following cycle.
  - Reset value of align_fault is 0.
- Undefined:
  - No port is added.
  - Odd targets load unchanged.

Decomposition:
- Shared package pc_pkg holds:
  - PC_SRC_SEQ/IMM/JR/RET encodings (2 bits).
  - BR_BEQ/BNE/BLT/ALWAYS encodings.
  - Default width constant 16.
- One sub-module, ras_stack (parameters WIDTH, RAS_DEPTH):
  - Inputs push, pop, din.
  - Outputs top, count, overflow/underflow strobes.
  - Synchronous reset; replace-top when push and pop are both asserted.
- The top level holds only the PC register, target mux, condition logic and ras_err.

Test Plan:
- Reset with RESET_VEC = 0x0100, then pc_write=1, pc_src=00, seq_in=0x0102 -> pc_out 0x0100 after reset, 0x0102 one cycle later.
- branch=1, br_cond=01, zero=1, imm=0x0040 -> PC holds. Then zero=0 -> pc_out=0x0080. Repeat with br_cond=10, neg=1 -> taken.
- Five calls (seq_in 0x10, 0x20, 0x30, 0x40, 0x50) with RAS_DEPTH=4 -> ras_full=1, ras_err=1. Then four returns -> targets 0x50, 0x40, 0x30, 0x20, ras_empty=1.
- Return on empty stack -> pc_out=RESET_VEC, ras_count stays 0, ras_err=1.
- call + pc_src=11 with stack [0x30] and seq_in=0x90 -> pc_out=0x30, ras_count=1; next return -> 0x90.
- stall=1 with pc_write=1 and call=1 -> no PC or RAS change. Under PC_ALIGN_CHECK_EN: jr_in=0x0203 -> PC holds, align_fault high for 1 cycle.
